// File: rtl/hh_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hh_step_scheduler
//  Brief    : Timestep sequencer for one shared Hodgkin-Huxley update engine.
//             Each accepted tick walks every neuron slot in ascending order
//             over a start/done handshake. It gathers the spike flags and
//             publishes them as one vector. It also tracks queued ticks,
//             dropped ticks and engine timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module hh_step_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   step_tick,
  input  logic                   clr_err,
  output logic                   eng_start,
  output logic [IDX_W-1:0]       eng_idx,
  input  logic                   eng_done,
  input  logic                   eng_spike,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   step_done,
  output logic                   busy,
  output logic                   pending,
  output logic                   overrun_err,
  output logic                   timeout_err
);

  // Index of the final slot in a step.
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  // Counter value in the last WAIT cycle a slot is allowed. The counter
  // reaches MAX_WAIT at the edge that ends that cycle.
  localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       idx;
  logic [NUM_NEURONS-1:0] scratch;
  logic [NUM_NEURONS-1:0] scratch_upd;
  logic [7:0]             wait_cnt;

  logic tick_accept;
  logic tick_queue;
  logic slot_done;
  logic slot_expire;
  logic slot_end;
  logic last_slot;

  // A new step starts from IDLE on a fresh or queued tick while enabled.
  assign tick_accept = (state == S_IDLE) && enable && (step_tick || pending);
  // Any tick that cannot start a step right now is queued, or it is dropped
  // if the queue is already full.
  assign tick_queue  = step_tick && !((state == S_IDLE) && enable);
  // A done wins over an expiry that falls in the same cycle.
  assign slot_done   = (state == S_WAIT) && eng_done;
  assign slot_expire = (state == S_WAIT) && !eng_done && (wait_cnt == WAIT_LAST);
  assign slot_end    = slot_done || slot_expire;
  assign last_slot   = (idx == LAST_IDX);

  // Outputs are decoded from registered state only.
  assign eng_start = (state == S_START);
  assign step_done = (state == S_PUBLISH);
  assign busy      = (state != S_IDLE);
  assign eng_idx   = idx;

  // Scratch vector with the current slot's result merged in. A timed-out
  // slot records no spike.
  always_comb begin
    scratch_upd      = scratch;
    scratch_upd[idx] = slot_done && eng_spike;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the per-slot handshake sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (tick_accept) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (slot_end) begin
          state_next = last_slot ? S_PUBLISH : S_START;
        end
      end
      S_PUBLISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Slot index, scratch capture, wait counter and published spike vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      scratch   <= '0;
      wait_cnt  <= '0;
      spike_vec <= '0;
    end else begin
      if (tick_accept) begin
        idx     <= '0;
        scratch <= '0;
      end else if (slot_end) begin
        scratch <= scratch_upd;
        if (!last_slot) begin
          idx <= idx + IDX_W'(1);
        end
      end

      if (state == S_START) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Publish at the edge entering PUBLISH, final slot's bit included.
      if (slot_end && last_slot) begin
        spike_vec <= scratch_upd;
      end
    end
  end

  // Tick queue and sticky error flags. A set event wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick_accept) begin
        pending <= 1'b0;
      end else if (tick_queue) begin
        pending <= 1'b1;
      end

      if (tick_queue && pending) begin
        overrun_err <= 1'b1;
      end else if (clr_err) begin
        overrun_err <= 1'b0;
      end

      if (slot_expire) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hh_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hh_step_scheduler
//  Brief    : Self-checking bench for hh_step_scheduler. It uses a latency
//             table, hand-written corner sequences and randomized steps
//             checked against a step-level timing/spike model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hh_step_scheduler;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int MAX_WAIT = 15;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          step_tick;
  logic          clr_err;
  logic          eng_start;
  logic [IW-1:0] eng_idx;
  logic          eng_done;
  logic          eng_spike;
  logic [N-1:0]  spike_vec;
  logic          step_done;
  logic          busy;
  logic          pending;
  logic          overrun_err;
  logic          timeout_err;

  int tests = 0;
  int fails = 0;

  // Engine behaviour: per-slot latency (0 or > MAX_WAIT = never answers) and spike.
  logic [N-1:0][7:0] eng_lat;
  logic [N-1:0]      eng_spk;

  hh_step_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .step_tick(step_tick),
    .clr_err(clr_err), .eng_start(eng_start), .eng_idx(eng_idx),
    .eng_done(eng_done), .eng_spike(eng_spike), .spike_vec(spike_vec),
    .step_done(step_done), .busy(busy), .pending(pending),
    .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Engine model: answers k cycles after eng_start; spike is noise unless done.
  initial begin
    int  cnt;
    int  cur;
    bit  active;
    cnt = 0; cur = 0; active = 0;
    eng_done = 1'b0;
    eng_spike = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eng_done  = 1'b0;
      eng_spike = 1'($urandom);
      if (rst) begin
        active = 0;
      end else if (eng_start) begin
        active = 1;
        cur    = int'(eng_idx);
        cnt    = 0;
      end else if (active) begin
        cnt++;
        if (eng_lat[cur] != 8'd0 && cnt == int'(eng_lat[cur])) begin
          eng_done  = 1'b1;
          eng_spike = eng_spk[cur];
          active    = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until step_done is seen; n = cycles advanced, or -1 on expiry.
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!step_done && n < bound) begin
      step();
      n++;
    end
    if (!step_done) n = -1;
  endtask

  // Step-level model: a slot answered in k cycles costs k+1 cycles, a silent
  // slot costs 1+MAX_WAIT cycles, records no spike and raises a timeout.
  function automatic void model(input logic [N-1:0][7:0] lat, input logic [N-1:0] spk,
                                output int cyc, output logic [N-1:0] vec, output bit to);
    cyc = 1; vec = '0; to = 0;
    for (int i = 0; i < N; i++) begin
      if (lat[i] >= 8'd1 && int'(lat[i]) <= MAX_WAIT) begin
        cyc += int'(lat[i]) + 1;
        vec[i] = spk[i];
      end else begin
        cyc += MAX_WAIT + 1;
        to = 1;
      end
    end
  endfunction

  // Run one full step from IDLE and compare against expectations.
  task automatic run_step(input string tag, input logic [N-1:0][7:0] lat,
                          input logic [N-1:0] spk, input bit drop_en,
                          input int exp_cyc, input logic [N-1:0] exp_vec, input bit exp_to);
    int cyc;
    int got;
    int nst;
    logic [N-1:0] vec_at_done;
    logic         to_at_done;
    eng_lat = lat;
    eng_spk = spk;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    if (drop_en) enable = 1'b0;
    cyc = 1; nst = 0; got = -1;
    vec_at_done = '0; to_at_done = 1'b0;
    while (cyc <= 200) begin
      if (eng_start) begin
        chk({tag, "_idx"}, 32'(eng_idx), 32'(nst));
        nst++;
      end
      if (step_done) begin
        got = cyc;
        vec_at_done = spike_vec;
        to_at_done  = timeout_err;
        break;
      end
      step();
      cyc++;
    end
    chk({tag, "_done_cycle"}, 32'(got), 32'(exp_cyc));
    chk({tag, "_spike_vec"}, 32'(vec_at_done), 32'(exp_vec));
    chk({tag, "_timeout"}, 32'(to_at_done), 32'(exp_to));
    chk({tag, "_starts"}, 32'(nst), 32'(N));
    enable = 1'b1;
    step();
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_vec_hold"}, 32'(spike_vec), 32'(exp_vec));
  endtask

  typedef struct {
    logic [N-1:0][7:0] lat;
    logic [N-1:0]      spk;
    int                cyc;
    logic [N-1:0]      vec;
    bit                to;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    int seen;
    int m_cyc;
    logic [N-1:0] m_vec;
    bit m_to;
    logic [N-1:0][7:0] rl;
    logic [N-1:0] rs;

    // Hand-derived expected step results.
    tbl[0] = '{lat: {8'd1, 8'd1, 8'd1, 8'd1},   spk: 4'b0101, cyc: 9,  vec: 4'b0101, to: 0};
    tbl[1] = '{lat: {8'd4, 8'd1, 8'd3, 8'd2},   spk: 4'b1111, cyc: 15, vec: 4'b1111, to: 0};
    tbl[2] = '{lat: {8'd1, 8'd0, 8'd1, 8'd1},   spk: 4'b1111, cyc: 23, vec: 4'b1011, to: 1};
    tbl[3] = '{lat: {8'd15, 8'd15, 8'd15, 8'd15}, spk: 4'b0110, cyc: 65, vec: 4'b0110, to: 0};
    tbl[4] = '{lat: {8'd0, 8'd0, 8'd0, 8'd0},   spk: 4'b1111, cyc: 65, vec: 4'b0000, to: 1};

    rst = 1'b1; enable = 1'b1; step_tick = 1'b0; clr_err = 1'b0;
    eng_lat = '0; eng_spk = '0;
    repeat (3) step();
    chk("reset_outputs", {23'd0, busy, eng_start, step_done, pending, overrun_err,
                          timeout_err, eng_idx, spike_vec}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_vec", 32'(spike_vec), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_step($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].spk, 1'b0,
               tbl[i].cyc, tbl[i].vec, tbl[i].to);
    end

    // Sticky timeout cleared by clr_err.
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("timeout_cleared", 32'(timeout_err), 32'd0);

    // Queueing and overrun during a busy step (k=2: step_done at cycle 13).
    eng_lat = {8'd2, 8'd2, 8'd2, 8'd2};
    eng_spk = 4'b0011;
    step_tick = 1'b1; step(); step_tick = 1'b0;
    step();
    step_tick = 1'b1; step(); step_tick = 1'b0;
    chk("queue_pending", 32'(pending), 32'd1);
    chk("queue_no_overrun", 32'(overrun_err), 32'd0);
    step_tick = 1'b1; step(); step_tick = 1'b0;
    chk("overrun_set", 32'(overrun_err), 32'd1);
    chk("overrun_pending", 32'(pending), 32'd1);
    wait_done(100, n);
    chk("queue_done_cycle", 32'(n), 32'd9);
    step();
    chk("b2b_idle_gap", {30'd0, busy, eng_start}, 32'd0);
    step();
    chk("b2b_start", 32'(eng_start), 32'd1);
    chk("b2b_pending_clr", 32'(pending), 32'd0);
    wait_done(100, n);
    chk("b2b_done_cycle", 32'(n), 32'd12);
    chk("b2b_vec", 32'(spike_vec), 32'h3);
    step();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("overrun_cleared", 32'(overrun_err), 32'd0);

    // Enable gating: tick held while disabled, serviced when enable rises.
    eng_lat = {8'd1, 8'd1, 8'd1, 8'd1};
    eng_spk = 4'b1111;
    enable = 1'b0;
    step_tick = 1'b1; step(); step_tick = 1'b0;
    chk("gate_no_start", 32'(eng_start), 32'd0);
    chk("gate_pending", 32'(pending), 32'd1);
    step();
    chk("gate_still_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    chk("gate_start", 32'(eng_start), 32'd1);
    chk("gate_start_idx", 32'(eng_idx), 32'd0);
    wait_done(100, n);
    chk("gate_done_cycle", 32'(n), 32'd8);
    chk("gate_vec", 32'(spike_vec), 32'hF);
    step();

    // Asynchronous reset during slot 1 (k=3: slot 1 START at cycle 5).
    eng_lat = {8'd3, 8'd3, 8'd3, 8'd3};
    step_tick = 1'b1; step(); step_tick = 1'b0;
    repeat (5) step();
    chk("rst_mid_slot1", {30'd0, busy, eng_idx == 2'd1}, 32'h3);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {23'd0, busy, eng_start, step_done, pending, overrun_err,
                            timeout_err, eng_idx, spike_vec}, 32'd0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (step_done || busy) seen++;
    end
    chk("rst_no_publish", 32'(seen), 32'd0);

    // Randomized steps against the step-level model.
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       rl[i] = 8'd0;
          1:       rl[i] = 8'($urandom_range(MAX_WAIT + 1, MAX_WAIT + 2));
          default: rl[i] = 8'($urandom_range(1, MAX_WAIT));
        endcase
      end
      rs = N'($urandom);
      model(rl, rs, m_cyc, m_vec, m_to);
      run_step($sformatf("rnd%0d", s), rl, rs, 1'($urandom), m_cyc, m_vec, m_to);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hh_step_scheduler.md
# hh_step_scheduler

Sequencing controller for a single, time-multiplexed Hodgkin-Huxley update engine shared by `NUM_NEURONS` neuron slots. Each simulation timestep tick makes the block issue one update request per slot, in ascending index order, over a start/done handshake. It collects each slot's spike flag into a scratch vector, publishes the full spike vector when the step completes, and flags engine timeouts and tick overruns. It sits between the timestep generator and the shared HH datapath, and its spike vector feeds the STDP synapse stage.

## Interface
- `NUM_NEURONS`, 4: number of neuron slots served per timestep (≥2).
- `IDX_W`, 2: slot index width, equal to clog2(`NUM_NEURONS`).
- `MAX_WAIT`, 15: WAIT cycles allowed per slot before timeout (1..255).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  permits new timesteps to start.
- `step_tick`  in  1  one-cycle timestep request pulse.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_idx`  out  IDX_W  slot being updated; stable from START until the slot completes.
- `eng_done`  in  1  engine finished the current slot.
- `eng_spike`  in  1  spike result, qualified by `eng_done`.
- `spike_vec`  out  NUM_NEURONS  spike flags from the last completed step; bit i is slot i.
- `step_done`  out  1  one-cycle pulse when `spike_vec` is freshly published.
- `busy`  out  1  high in any state other than IDLE.
- `pending`  out  1  one queued tick awaiting service.
- `overrun_err`  out  1  sticky; a tick was dropped.
- `timeout_err`  out  1  sticky; the engine failed to answer within `MAX_WAIT`.

## Operation
- **Reset:** all outputs, `idx`, scratch, and the wait counter clear to 0; state goes to IDLE.
- **States:** IDLE, START, WAIT, PUBLISH.
- **IDLE → START:** when (`step_tick` or `pending`) and `enable`.
  - Clears `idx`, scratch, and `pending`.
- **START:** `eng_start` = 1 and `eng_idx` = `idx`.
  - Clears the wait counter.
  - Goes to WAIT unconditionally.
  - `eng_done` is ignored in START.
- **WAIT:** increments the wait counter each cycle.
  - **`eng_done` = 1:** `scratch[idx]` ← `eng_spike`. If `idx` = `NUM_NEURONS`−1, go to PUBLISH; otherwise increment `idx` and go to START.
  - **No done, counter reaches `MAX_WAIT`:** set `timeout_err`, write `scratch[idx]` ← 0, and advance exactly as on done.
  - **Done in the same cycle the counter expires:** done wins; no error is flagged.
- **PUBLISH:** `step_done` = 1, then go to IDLE.
  - `spike_vec` is loaded at the edge entering PUBLISH, including the final slot's bit.
  - `spike_vec` holds its value until the next PUBLISH.
- **Tick arriving while `busy`:**
  - If `pending` = 0, set `pending`.
  - If `pending` = 1, the tick is dropped and `overrun_err` is set.
- **Tick in IDLE with `enable` = 0:** set `pending` (with the same overrun rule). The queued tick is serviced once `enable` rises.
- **`enable` falling mid-step:** the current step completes normally.
- **`clr_err`:** clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- **`rst` mid-step:** the step is abandoned immediately. `spike_vec` is cleared; there is no partial publish.

## Timing
- Tick sampled in IDLE at edge 0 → `busy` and `eng_start` are high in cycle 1.
- **Engine answering k cycles after `eng_start` (1 ≤ k ≤ `MAX_WAIT`):**
  - Consecutive `eng_start` pulses are spaced k+1 cycles apart.
  - `step_done` is high in cycle 1 + `NUM_NEURONS`·(k+1).
- **Timed-out slot:** occupies 1 + `MAX_WAIT` cycles.
- **Back-to-back steps:** a pending tick gives START one cycle after PUBLISH (one IDLE cycle).
- **Output style:** all outputs are registered or decoded from state only. There is no combinational path from input to output.

## Test plan
- **Nominal step:** `NUM_NEURONS`=4, engine with k=1 returning spikes 1,0,1,0 for slots 0..3, tick at cycle 0.
  - `eng_start` pulses in cycles 1, 3, 5, 7 with `eng_idx` 0..3.
  - `step_done` in cycle 9 with `spike_vec` = 4'b0101; `busy` low in cycle 10.
- **Timeout:** engine never answers slot 2, `MAX_WAIT`=15.
  - `timeout_err` sets after 15 WAIT cycles and bit 2 = 0.
  - Slot 3 starts on the next cycle; the step still publishes.
  - `clr_err` then clears the flag.
- **Queueing and overrun:** two extra ticks during a busy step.
  - First extra tick: `pending`=1.
  - Second extra tick: `overrun_err`=1.
  - The next step's START occurs exactly 2 cycles after `step_done`.
- **Enable gating:** tick with `enable`=0.
  - No `eng_start` occurs and `pending`=1.
  - Raising `enable` produces `eng_start` on the following cycle.
- **Race and reset:**
  - `eng_done` in the same cycle the wait counter hits `MAX_WAIT` → no `timeout_err`, and the spike is captured.
  - `rst` asserted during slot 1 → all outputs are 0 immediately, state is IDLE, and no `step_done`.
